// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, D_BIT data bits, SB_TICK-tick stop bit.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_rx #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             s_tick,
  output logic             rx_done_tick,
  output logic [D_BIT-1:0] dout,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int N_W = (D_BIT > 1) ? $clog2(D_BIT) : 1;
  // Widened beyond 4 bits only when the stop bit needs more than 16 ticks.
  localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           r_state, w_state_next;
  logic [S_W-1:0]   r_s, w_s_next;
  logic [N_W-1:0]   r_n, w_n_next;
  logic [D_BIT-1:0] r_shreg, w_shreg_next;
  logic [D_BIT-1:0] r_dout, w_dout_next;
  logic             r_ferr, w_ferr_next;
  logic             r_done, w_done_next;
`ifdef UART_RX_PARITY_EN
  logic             r_pbit, w_pbit_next;
  logic             r_perr, w_perr_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shreg <= '0;
      r_dout  <= '0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_pbit  <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_shreg <= w_shreg_next;
      r_dout  <= w_dout_next;
      r_ferr  <= w_ferr_next;
      r_done  <= w_done_next;
`ifdef UART_RX_PARITY_EN
      r_pbit  <= w_pbit_next;
      r_perr  <= w_perr_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_shreg_next = r_shreg;
    w_dout_next  = r_dout;
    w_ferr_next  = r_ferr;
    w_done_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pbit_next  = r_pbit;
    w_perr_next  = r_perr;
`endif
    case (r_state)
      IDLE: begin
        if (!rx) begin
          w_state_next = START;
          w_s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == S_W'(7)) begin
            w_s_next     = '0;
            w_n_next     = '0;
            w_state_next = rx ? IDLE : DATA;
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == S_W'(15)) begin
            w_s_next     = '0;
            w_shreg_next = {rx, r_shreg[D_BIT-1:1]};
            if (r_n == N_W'(D_BIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = PARITY;
`else
              w_state_next = STOP;
`endif
            end else begin
              w_n_next = r_n + N_W'(1);
            end
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_s == S_W'(15)) begin
            w_s_next     = '0;
            w_pbit_next  = rx;
            w_state_next = STOP;
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (r_s == S_W'(SB_TICK - 1)) begin
            w_s_next     = '0;
            w_state_next = IDLE;
            w_dout_next  = r_shreg;
            w_ferr_next  = ~rx;
            w_done_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_next  = (^r_shreg) ^ r_pbit;
`endif
          end else begin
            w_s_next = r_s + S_W'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_done_tick = r_done;
    dout         = r_dout;
    frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
    parity_err   = r_perr;
`else
    parity_err   = 1'b0;
`endif
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: D_BIT, 8, number of data bits per frame (5..9).
REQ-002 Parameter: SB_TICK, 16, stop-bit length in s_tick periods (16/24/32 = 1/1.5/2 stop bits).
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: rx  input  1  serial line, idle high, already synchronised upstream.
REQ-006 Port: s_tick  input  1  one-clk strobe at 16x baud rate, from the baud generator.
REQ-007 Port: rx_done_tick  output  1  one-clk pulse when a frame completes; drives the downstream register's en.
REQ-008 Port: dout  output  D_BIT  received word; drives the downstream register's d.
REQ-009 Port: frame_err  output  1  stop bit sampled low in the last frame.
REQ-010 Port: parity_err  output  1  parity mismatch in the last frame (see Configuration).

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY (macro only) and STOP, with a 4-bit tick counter s and a bit counter n of width clog2(D_BIT).
REQ-012 IDLE: rx==0 sampled on any clk SHALL move to START with s=0; s_tick is ignored in IDLE.
REQ-013 START: on each s_tick s increments; at s==7 with rx==0 -> DATA, s=0, n=0; at s==7 with rx==1 -> IDLE (false start, no output change).
REQ-014 DATA: on s_tick at s==15 the SHALL shift LSB-first (shift reg <= {rx, shreg[D_BIT-1:1]}), s=0, n increments; after bit n==D_BIT-1 -> PARITY if enabled, else STOP.
REQ-015 STOP: on s_tick at s==SB_TICK-1 -> IDLE; the same clk edge SHALL load dout from the shift register, set frame_err=~rx, set parity_err, and assert rx_done_tick for exactly one clk.
REQ-016 Clk cycles without s_tick SHALL hold s, n and state (except the IDLE start detect).
REQ-017 dout, frame_err and parity_err SHALL hold their values until the next completed frame; a false start or reset-free abort SHALL not alter them.
REQ-018 Latency: rx_done_tick SHALL be asserted on the clk edge of the stop-bit's final s_tick, i.e. (1 + D_BIT [+1] ) x 16 + SB_TICK - 8 ticks after the start-bit falling edge, as measured at the s_tick boundary.
REQ-019 A falling edge on rx during DATA/STOP SHALL not restart the frame; the next frame is detected only from IDLE.
REQ-020 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-021 rst high SHALL force state=IDLE, s=0, n=0, shift register=0, dout=0, rx_done_tick=0, frame_err=0, parity_err=0 immediately, regardless of clk.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick; reception restarts at the next falling edge after rst deasserts.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: PARITY state SHALL follow DATA, sample one bit at s==15, and parity_err = (XOR of data bits) ^ sampled bit (even parity), then -> STOP.
REQ-024 Macro undefined: PARITY state and logic SHALL be absent, DATA -> STOP directly, parity_err SHALL be tied 0.

Verification
REQ-025 Frame 0xA5, 1 stop, 16 ticks/bit -> exactly one rx_done_tick, dout=0xA5, frame_err=0, parity_err=0.
REQ-026 rx low for 4 ticks then high -> no rx_done_tick, dout unchanged, FSM back in IDLE by tick 8.
REQ-027 Frame 0x3C with stop bit held low -> rx_done_tick, dout=0x3C, frame_err=1; next clean frame 0x01 clears frame_err=0.
REQ-028 rst pulse at data bit 4 of 0xFF, then full frame 0x55 -> no pulse for aborted frame, dout=0x00 after reset, then 0x55.
REQ-029 Back-to-back frames 0x00, 0xFF -> two rx_done_tick pulses, dout 0x00 then 0xFF; downstream register q matches each.
REQ-030 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.
